// File: rtl/serdes2axi4stream_if.sv
// ---------------------------------------------------------------------------
// serdes2axi4stream_if
//
// Purpose:
//   Bundles the AW descriptor channel and the W data channel that the
//   serdes2axi4stream receiver drives toward the downstream AXI consumer.
//
// Signals:
//   M_AWPORT   destination port taken from the frame header
//   M_AWLEN    payload length in bytes
//   M_AWVALID  descriptor valid            (master -> slave)
//   M_AWREADY  descriptor ready            (slave  -> master)
//   M_WVALID   data beat valid             (master -> slave)
//   M_WREADY   data beat ready             (slave  -> master)
//   M_WDATA    64-bit little-endian payload word
//   M_WSTRB    byte enables of the beat
//   M_WLAST    final beat of the frame
//
// Modports:
//   master  used by the receiver
//   slave   used by the consumer
// ---------------------------------------------------------------------------
interface serdes2axi4stream_if #(
    parameter int AWPORT_WIDTH = 2,
    parameter int AWLEN_WIDTH  = 16,
    parameter int MDATA_WIDTH  = 64
) ();

    logic [AWPORT_WIDTH-1:0]  M_AWPORT;
    logic [AWLEN_WIDTH-1:0]   M_AWLEN;
    logic                     M_AWVALID;
    logic                     M_AWREADY;
    logic                     M_WVALID;
    logic                     M_WREADY;
    logic [MDATA_WIDTH-1:0]   M_WDATA;
    logic [MDATA_WIDTH/8-1:0] M_WSTRB;
    logic                     M_WLAST;

    modport master (
        output M_AWPORT,
        output M_AWLEN,
        output M_AWVALID,
        input  M_AWREADY,
        output M_WVALID,
        input  M_WREADY,
        output M_WDATA,
        output M_WSTRB,
        output M_WLAST
    );

    modport slave (
        input  M_AWPORT,
        input  M_AWLEN,
        input  M_AWVALID,
        output M_AWREADY,
        input  M_WVALID,
        output M_WREADY,
        input  M_WDATA,
        input  M_WSTRB,
        input  M_WLAST
    );

endinterface

// File: rtl/serdes2axi4stream.sv
// ---------------------------------------------------------------------------
// serdes2axi4stream
//
// Purpose:
//   Receive side of the SERDES link. Hunts for the 0xA5,0xA5 sync pair in the
//   recovered byte stream, parses PORT / LEN_H / LEN_L, packs the payload
//   into a local buffer of 64-bit words, checks the trailing CRC8 and then
//   replays the frame as one AW descriptor followed by ceil(LEN/8) W beats.
//   Frame status is reported to the link-level ack logic as one-cycle pulses.
//
// Frame on accepted bytes:
//   0xA5 0xA5 PORT LEN_H LEN_L payload[LEN] CRC8
//   CRC8: poly 0x07, init 0x00, MSB first, over PORT .. last payload byte.
//
// Optional feature:
//   SERDES_RX_CRC_CHECK_EN  when defined the CRC8 is computed and a mismatch
//                           rejects the frame; when undefined the CRC byte is
//                           consumed and ignored and no CRC logic exists.
//
// Ports:
//   CLK_I       SERDES parallel clock (single clock domain)
//   RST_I       asynchronous active-high reset
//   RX_DATA_I   received byte
//   RX_VALID_I  byte strobe, no backpressure toward the link
//   RX_ACK_O    one-cycle pulse, frame fully delivered
//   RX_NAK_O    one-cycle pulse, frame rejected (bad LEN, bad CRC, timeout)
//   RX_DROP_O   one-cycle pulse, sync pair seen while emitting
//   BUSY_O      high from first sync byte until the last W beat is accepted
//   m_axi       AW / W channels (serdes2axi4stream_if.master)
// ---------------------------------------------------------------------------
module serdes2axi4stream #(
    parameter int MDATA_WIDTH   = 64,
    parameter int AWPORT_WIDTH  = 2,
    parameter int AWLEN_WIDTH   = 16,
    parameter int MAX_LEN       = 256,
    parameter int BYTE_TIME_OUT = 1000
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic [7:0]           RX_DATA_I,
    input  logic                 RX_VALID_I,
    output logic                 RX_ACK_O,
    output logic                 RX_NAK_O,
    output logic                 RX_DROP_O,
    output logic                 BUSY_O,
    serdes2axi4stream_if.master  m_axi
);

    localparam int DEPTH  = MAX_LEN / 8;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_W = MDATA_WIDTH / 8;
    localparam int TO_W   = $clog2(BYTE_TIME_OUT + 1);

    localparam logic [7:0]      SYNC_BYTE = 8'hA5;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(BYTE_TIME_OUT - 1);
    localparam logic [15:0]     LEN_MAX   = 16'(MAX_LEN);

    typedef enum logic [3:0] {
        HUNT,
        SYNC2,
        PORT,
        LENH,
        LENL,
        DATA,
        CRC,
        EMIT_AW,
        EMIT_W
    } state_t;

    state_t                   r_state;
    logic [AWPORT_WIDTH-1:0]  r_port;
    logic [7:0]               r_lenH;
    logic [AWLEN_WIDTH-1:0]   r_len;
    logic [15:0]              r_byteCnt;
    logic [MDATA_WIDTH-1:0]   r_word;
    logic [TO_W-1:0]          r_idle;
    logic [ADDR_W-1:0]        r_lastBeat;
    logic [ADDR_W-1:0]        r_beat;
    logic                     r_awvalid;
    logic                     r_wvalid;
    logic [MDATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]        r_wstrb;
    logic                     r_wlast;
    logic                     r_ack;
    logic                     r_nak;
    logic                     r_drop;
    logic                     r_busy;
    logic                     r_pairA5;

    logic [MDATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [15:0]              w_lenFull;
    logic                     w_lenBad;
    logic [2:0]               w_pos;
    logic                     w_lastByte;
    logic [MDATA_WIDTH-1:0]   w_wordNext;
    logic                     w_memWe;
    logic [ADDR_W-1:0]        w_memAddr;
    logic [ADDR_W-1:0]        w_beatNext;
    logic [STRB_W-1:0]        w_lastStrb;
    logic                     w_crcOk;
    logic                     w_isSync;

    // Length as it stands once LEN_L arrives, and its legality window.
    assign w_lenFull = {r_lenH, RX_DATA_I};
    assign w_lenBad  = (w_lenFull == 16'd0) || (w_lenFull > LEN_MAX);
    assign w_isSync  = (RX_DATA_I == SYNC_BYTE);

    // Payload byte k lands in word k/8 at byte lane k%8.
    assign w_pos      = r_byteCnt[2:0];
    assign w_memAddr  = r_byteCnt[ADDR_W+2:3];
    assign w_lastByte = (r_byteCnt == (16'(r_len) - 16'd1));
    assign w_memWe    = (r_state == DATA) && RX_VALID_I && ((w_pos == 3'd7) || w_lastByte);
    assign w_beatNext = r_beat + 1'b1;

    // Starting a fresh word clears the stale upper lanes so a short final
    // word is zero-filled above the last payload byte.
    always_comb begin
        w_wordNext = (w_pos == 3'd0) ? '0 : r_word;
        w_wordNext[{w_pos, 3'b000} +: 8] = RX_DATA_I;
    end

    // Strobe pattern of the final beat: only the lanes actually carrying
    // payload, or a full word when LEN is a multiple of eight.
    always_comb begin
        w_lastStrb = '1;
        if (r_len[2:0] != 3'd0) begin
            w_lastStrb = STRB_W'((9'd1 << r_len[2:0]) - 9'd1);
        end
    end

`ifdef SERDES_RX_CRC_CHECK_EN
    logic [7:0] r_crc;
    logic [7:0] w_crcNext;

    function automatic logic [7:0] crc8Next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign w_crcNext = crc8Next(r_crc, RX_DATA_I);
    assign w_crcOk   = (RX_DATA_I == r_crc);

    // Running CRC: cleared on the second sync byte, then folded over every
    // header and payload byte. In CRC state it holds the value to compare.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_crc <= 8'h00;
        end else if (RX_VALID_I) begin
            if (r_state == SYNC2) begin
                r_crc <= 8'h00;
            end else if ((r_state == PORT) || (r_state == LENH) ||
                         (r_state == LENL) || (r_state == DATA)) begin
                r_crc <= w_crcNext;
            end
        end
    end
`else
    assign w_crcOk = 1'b1;
`endif

    // Payload buffer write port. No reset: contents are only read back for
    // words that the current frame has written.
    always_ff @(posedge CLK_I) begin
        if (w_memWe) begin
            r_mem[w_memAddr] <= w_wordNext;
        end
    end

    // Main receive / emit state machine. Every output is a register here so
    // the AXI side and the status pulses are glitch free. Status pulses are
    // defaulted low each cycle and raised for exactly one cycle on events.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state    <= HUNT;
            r_port     <= '0;
            r_lenH     <= '0;
            r_len      <= '0;
            r_byteCnt  <= '0;
            r_word     <= '0;
            r_idle     <= '0;
            r_lastBeat <= '0;
            r_beat     <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wlast    <= 1'b0;
            r_ack      <= 1'b0;
            r_nak      <= 1'b0;
            r_drop     <= 1'b0;
            r_busy     <= 1'b0;
            r_pairA5   <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_nak  <= 1'b0;
            r_drop <= 1'b0;

            // While emitting, incoming bytes are not parsed but each
            // complete 0xA5,0xA5 pair is reported once as a dropped frame.
            if (((r_state == EMIT_AW) || (r_state == EMIT_W)) && RX_VALID_I) begin
                if (w_isSync && r_pairA5) begin
                    r_drop   <= 1'b1;
                    r_pairA5 <= 1'b0;
                end else begin
                    r_pairA5 <= w_isSync;
                end
            end

            case (r_state)
                HUNT: begin
                    if (RX_VALID_I && w_isSync) begin
                        r_state <= SYNC2;
                        r_busy  <= 1'b1;
                        r_idle  <= '0;
                    end
                end

                SYNC2, PORT, LENH, LENL, DATA, CRC: begin
                    if (!RX_VALID_I) begin
                        if (r_idle == TO_LAST) begin
                            r_nak   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= HUNT;
                        end else begin
                            r_idle <= r_idle + 1'b1;
                        end
                    end else begin
                        r_idle <= '0;
                        case (r_state)
                            SYNC2: begin
                                if (w_isSync) begin
                                    r_state <= PORT;
                                end else begin
                                    r_busy  <= 1'b0;
                                    r_state <= HUNT;
                                end
                            end
                            PORT: begin
                                r_port  <= RX_DATA_I[AWPORT_WIDTH-1:0];
                                r_state <= LENH;
                            end
                            LENH: begin
                                r_lenH  <= RX_DATA_I;
                                r_state <= LENL;
                            end
                            LENL: begin
                                if (w_lenBad) begin
                                    r_nak   <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= HUNT;
                                end else begin
                                    r_len      <= AWLEN_WIDTH'(w_lenFull);
                                    r_lastBeat <= ADDR_W'((w_lenFull - 16'd1) >> 3);
                                    r_byteCnt  <= '0;
                                    r_state    <= DATA;
                                end
                            end
                            DATA: begin
                                r_word    <= w_wordNext;
                                r_byteCnt <= r_byteCnt + 16'd1;
                                if (w_lastByte) begin
                                    r_state <= CRC;
                                end
                            end
                            CRC: begin
                                if (w_crcOk) begin
                                    r_awvalid <= 1'b1;
                                    r_pairA5  <= 1'b0;
                                    r_state   <= EMIT_AW;
                                end else begin
                                    r_nak   <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= HUNT;
                                end
                            end
                            default: begin
                                r_state <= HUNT;
                            end
                        endcase
                    end
                end

                // The first word is fetched on the AW handshake so WVALID
                // can rise on the very next cycle.
                EMIT_AW: begin
                    if (m_axi.M_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wdata   <= r_mem[0];
                        r_beat    <= '0;
                        r_wlast   <= (r_lastBeat == '0);
                        r_wstrb   <= (r_lastBeat == '0) ? w_lastStrb : '1;
                        r_state   <= EMIT_W;
                    end
                end

                // Each accepted beat prefetches the following word, giving
                // one beat per cycle while WREADY stays high. Without a
                // handshake every W field is left untouched.
                EMIT_W: begin
                    if (m_axi.M_WREADY) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_wstrb  <= '0;
                            r_wdata  <= '0;
                            r_ack    <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= HUNT;
                        end else begin
                            r_beat  <= w_beatNext;
                            r_wdata <= r_mem[w_beatNext];
                            r_wlast <= (w_beatNext == r_lastBeat);
                            r_wstrb <= (w_beatNext == r_lastBeat) ? w_lastStrb : '1;
                        end
                    end
                end

                default: begin
                    r_state <= HUNT;
                end
            endcase
        end
    end

    assign RX_ACK_O        = r_ack;
    assign RX_NAK_O        = r_nak;
    assign RX_DROP_O       = r_drop;
    assign BUSY_O          = r_busy;
    assign m_axi.M_AWPORT  = r_port;
    assign m_axi.M_AWLEN   = r_len;
    assign m_axi.M_AWVALID = r_awvalid;
    assign m_axi.M_WVALID  = r_wvalid;
    assign m_axi.M_WDATA   = r_wdata;
    assign m_axi.M_WSTRB   = r_wstrb;
    assign m_axi.M_WLAST   = r_wlast;

endmodule

// File: tb/tb_serdes2axi4stream.sv
// ---------------------------------------------------------------------------
// tb_serdes2axi4stream
//
// Directed and randomized frames are pushed into the receiver; a reference
// model builds expected AW/W traffic straight from the frame rules (byte k
// in word k/8 lane k%8, strobes from the number of bytes left in each word,
// bit-serial CRC8) and compares it against what the monitor captured.
// ---------------------------------------------------------------------------
module tb_serdes2axi4stream;

    localparam int TO   = 40;
    localparam int MAXL = 256;

    logic       CLK_I      = 1'b0;
    logic       RST_I      = 1'b1;
    logic [7:0] RX_DATA_I  = 8'h00;
    logic       RX_VALID_I = 1'b0;
    logic       RX_ACK_O;
    logic       RX_NAK_O;
    logic       RX_DROP_O;
    logic       BUSY_O;

    serdes2axi4stream_if #(.AWPORT_WIDTH(2), .AWLEN_WIDTH(16), .MDATA_WIDTH(64)) axi ();

    serdes2axi4stream #(
        .MDATA_WIDTH(64), .AWPORT_WIDTH(2), .AWLEN_WIDTH(16),
        .MAX_LEN(MAXL), .BYTE_TIME_OUT(TO)
    ) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .RX_DATA_I  (RX_DATA_I),
        .RX_VALID_I (RX_VALID_I),
        .RX_ACK_O   (RX_ACK_O),
        .RX_NAK_O   (RX_NAK_O),
        .RX_DROP_O  (RX_DROP_O),
        .BUSY_O     (BUSY_O),
        .m_axi      (axi)
    );

    always #5 CLK_I = ~CLK_I;

    int testCount = 0;
    int failCount = 0;

    // Scoreboard state filled by the monitor.
    int          ackCount, nakCount, dropCount, awCount, stabErr;
    logic [1:0]  awPortSeen;
    logic [15:0] awLenSeen;
    logic [63:0] gotData[$];
    logic [7:0]  gotStrb[$];
    logic        gotLast[$];

    // Stimulus state.
    logic [7:0]  txq[$];
    logic [7:0]  payload[$];
    logic [7:0]  portByte;
    int          wrMode  = 0;
    int          awDelay = 0;
    int          awWait  = 0;

    // Ready generation for the AXI consumer, updated just after each edge.
    initial begin
        axi.M_AWREADY = 1'b1;
        axi.M_WREADY  = 1'b1;
    end

    always @(posedge CLK_I) begin
        #1;
        case (wrMode)
            0:       axi.M_WREADY = 1'b1;
            1:       axi.M_WREADY = ~axi.M_WREADY;
            default: axi.M_WREADY = 1'($urandom_range(0, 1));
        endcase
        if (awDelay == 0) begin
            axi.M_AWREADY = 1'b1;
            awWait = 0;
        end else begin
            if (axi.M_AWVALID) awWait++;
            else awWait = 0;
            axi.M_AWREADY = axi.M_AWVALID && (awWait > awDelay);
        end
    end

    // Monitor: samples on the falling edge, counts pulses, captures
    // handshakes and flags any channel that changes while stalled.
    logic        prevWStall = 1'b0, prevAwStall = 1'b0;
    logic [63:0] prevData;
    logic [7:0]  prevStrb;
    logic        prevLast;
    logic [1:0]  prevPort;
    logic [15:0] prevLen;

    always @(negedge CLK_I) begin
        if (!RST_I) begin
            if (RX_ACK_O)  ackCount++;
            if (RX_NAK_O)  nakCount++;
            if (RX_DROP_O) dropCount++;
            if (prevAwStall && (!axi.M_AWVALID || axi.M_AWPORT !== prevPort || axi.M_AWLEN !== prevLen))
                stabErr++;
            if (prevWStall && (!axi.M_WVALID || axi.M_WDATA !== prevData ||
                               axi.M_WSTRB !== prevStrb || axi.M_WLAST !== prevLast))
                stabErr++;
            if (axi.M_AWVALID && axi.M_AWREADY) begin
                awCount++;
                awPortSeen = axi.M_AWPORT;
                awLenSeen  = axi.M_AWLEN;
            end
            if (axi.M_WVALID && axi.M_WREADY) begin
                gotData.push_back(axi.M_WDATA);
                gotStrb.push_back(axi.M_WSTRB);
                gotLast.push_back(axi.M_WLAST);
            end
        end
        prevAwStall = axi.M_AWVALID && !axi.M_AWREADY && !RST_I;
        prevWStall  = axi.M_WVALID && !axi.M_WREADY && !RST_I;
        prevData = axi.M_WDATA;
        prevStrb = axi.M_WSTRB;
        prevLast = axi.M_WLAST;
        prevPort = axi.M_AWPORT;
        prevLen  = axi.M_AWLEN;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearScore();
        ackCount = 0; nakCount = 0; dropCount = 0; awCount = 0; stabErr = 0;
        gotData.delete(); gotStrb.delete(); gotLast.delete();
    endtask

    // Bit-serial CRC8 (poly 0x07, init 0) over PORT, LEN_H, LEN_L, payload.
    function automatic logic [7:0] refCrc();
        logic [7:0] msg[$];
        logic [7:0] c = 8'h00;
        logic       fb;
        int         len = payload.size();
        msg.push_back(portByte);
        msg.push_back(8'(len >> 8));
        msg.push_back(8'(len & 255));
        foreach (payload[i]) msg.push_back(payload[i]);
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ msg[i][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic randomPayload(input int len);
        payload.delete();
        for (int i = 0; i < len; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic buildHeader(input int len);
        txq.delete();
        txq.push_back(8'hA5);
        txq.push_back(8'hA5);
        txq.push_back(portByte);
        txq.push_back(8'(len >> 8));
        txq.push_back(8'(len & 255));
    endtask

    task automatic buildFrame(input logic [7:0] crcFlip);
        buildHeader(payload.size());
        foreach (payload[i]) txq.push_back(payload[i]);
        txq.push_back(refCrc() ^ crcFlip);
    endtask

    // Drives every byte of txq back to back; returns just after the edge
    // that accepts the last one.
    task automatic applyStimulus();
        foreach (txq[i]) begin
            @(posedge CLK_I); #1;
            RX_DATA_I  = txq[i];
            RX_VALID_I = 1'b1;
        end
        @(posedge CLK_I); #1;
        RX_VALID_I = 1'b0;
        RX_DATA_I  = 8'h00;
    endtask

    task automatic waitEnd(input string tag, input int budget, output int cycles);
        cycles = 0;
        while ((ackCount + nakCount) == 0 && cycles < budget) begin
            @(negedge CLK_I); #1;
            cycles++;
        end
        checkOutput({tag, "_done"}, 64'((ackCount + nakCount) != 0), 64'(1));
        repeat (3) @(negedge CLK_I);
    endtask

    // Compares the captured AW/W traffic against the current payload.
    task automatic checkFrame(input string tag);
        int          len = payload.size();
        int          nb  = (len + 7) / 8;
        int          n;
        logic [63:0] ed;
        logic [7:0]  es;
        checkOutput({tag, "_awCount"}, 64'(awCount), 64'(1));
        checkOutput({tag, "_awPort"}, 64'(awPortSeen), 64'(portByte[1:0]));
        checkOutput({tag, "_awLen"}, 64'(awLenSeen), 64'(len));
        checkOutput({tag, "_beats"}, 64'(gotData.size()), 64'(nb));
        for (int w = 0; w < nb && w < gotData.size(); w++) begin
            n  = (len - 8 * w > 8) ? 8 : len - 8 * w;
            ed = 64'h0;
            for (int i = 0; i < n; i++) ed = ed | (64'(payload[8 * w + i]) << (8 * i));
            es = 8'((1 << n) - 1);
            checkOutput($sformatf("%s_data%0d", tag, w), gotData[w], ed);
            checkOutput($sformatf("%s_strb%0d", tag, w), 64'(gotStrb[w]), 64'(es));
            checkOutput($sformatf("%s_last%0d", tag, w), 64'(gotLast[w]), 64'(w == nb - 1));
        end
        checkOutput({tag, "_ack"}, 64'(ackCount), 64'(1));
        checkOutput({tag, "_nak"}, 64'(nakCount), 64'(0));
        checkOutput({tag, "_stable"}, 64'(stabErr), 64'(0));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ack"}, 64'(RX_ACK_O), 64'(0));
        checkOutput({tag, "_nak"}, 64'(RX_NAK_O), 64'(0));
        checkOutput({tag, "_drop"}, 64'(RX_DROP_O), 64'(0));
        checkOutput({tag, "_busy"}, 64'(BUSY_O), 64'(0));
        checkOutput({tag, "_awvalid"}, 64'(axi.M_AWVALID), 64'(0));
        checkOutput({tag, "_awport"}, 64'(axi.M_AWPORT), 64'(0));
        checkOutput({tag, "_awlen"}, 64'(axi.M_AWLEN), 64'(0));
        checkOutput({tag, "_wvalid"}, 64'(axi.M_WVALID), 64'(0));
        checkOutput({tag, "_wdata"}, axi.M_WDATA, 64'(0));
        checkOutput({tag, "_wstrb"}, 64'(axi.M_WSTRB), 64'(0));
        checkOutput({tag, "_wlast"}, 64'(axi.M_WLAST), 64'(0));
    endtask

    initial begin
        int cyc;

        // Reset state.
        clearScore();
        repeat (3) @(negedge CLK_I);
        checkIdleOutputs("reset");
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
        repeat (2) @(negedge CLK_I);

        // Directed frame: PORT=2, LEN=11, payload 0x01..0x0B.
        clearScore();
        portByte = 8'h02;
        payload.delete();
        for (int i = 1; i <= 11; i++) payload.push_back(8'(i));
        buildFrame(8'h00);
        applyStimulus();
        @(negedge CLK_I);
        checkOutput("t1_awLatency", 64'(axi.M_AWVALID), 64'(1));
        @(negedge CLK_I);
        checkOutput("t1_awDropped", 64'(axi.M_AWVALID), 64'(0));
        checkOutput("t1_wLatency", 64'(axi.M_WVALID), 64'(1));
        @(negedge CLK_I);
        checkOutput("t1_backToBack", 64'(axi.M_WVALID && axi.M_WLAST), 64'(1));
        waitEnd("t1", 200, cyc);
        checkFrame("t1");
        checkOutput("t1_beat0", gotData[0], 64'h0807060504030201);
        checkOutput("t1_beat1", gotData[1], 64'h00000000000B0A09);
        checkOutput("t1_strb1", 64'(gotStrb[1]), 64'h07);

        // Same frame with corrupted CRC.
        clearScore();
        buildFrame(8'h01);
        applyStimulus();
        waitEnd("t2", 200, cyc);
`ifdef SERDES_RX_CRC_CHECK_EN
        checkOutput("t2_nak", 64'(nakCount), 64'(1));
        checkOutput("t2_noAw", 64'(awCount), 64'(0));
        checkOutput("t2_noAck", 64'(ackCount), 64'(0));
`else
        checkFrame("t2");
`endif

        // Illegal lengths are rejected right after LEN_L.
        clearScore();
        portByte = 8'h01;
        buildHeader(0);
        applyStimulus();
        checkOutput("t3_len0_nakTiming", 64'(RX_NAK_O), 64'(1));
        waitEnd("t3_len0", 50, cyc);
        checkOutput("t3_len0_nak", 64'(nakCount), 64'(1));
        checkOutput("t3_len0_noAw", 64'(awCount), 64'(0));

        clearScore();
        buildHeader(MAXL + 1);
        applyStimulus();
        waitEnd("t3_lenMax1", 50, cyc);
        checkOutput("t3_lenMax1_nak", 64'(nakCount), 64'(1));
        checkOutput("t3_lenMax1_noAw", 64'(awCount), 64'(0));

        // Maximum length frame: 32 full beats.
        clearScore();
        portByte = 8'h03;
        randomPayload(MAXL);
        buildFrame(8'h00);
        applyStimulus();
        waitEnd("t4", 500, cyc);
        checkFrame("t4");

        // Stall after three payload bytes until the idle timeout fires.
        clearScore();
        portByte = 8'h01;
        randomPayload(20);
        buildFrame(8'h00);
        while (txq.size() > 8) void'(txq.pop_back());
        applyStimulus();
        waitEnd("t5", TO + 20, cyc);
        checkOutput("t5_nak", 64'(nakCount), 64'(1));
        checkOutput("t5_noAck", 64'(ackCount), 64'(0));
        checkOutput("t5_window", 64'(cyc >= TO && cyc <= TO + 2), 64'(1));
        clearScore();
        randomPayload(13);
        buildFrame(8'h00);
        applyStimulus();
        waitEnd("t5b", 200, cyc);
        checkFrame("t5b");

        // Delayed AWREADY, toggling WREADY and a sync pair during emission.
        clearScore();
        awDelay = 5;
        wrMode  = 1;
        portByte = 8'h02;
        randomPayload(16);
        buildFrame(8'h00);
        applyStimulus();
        txq.delete();
        txq.push_back(8'hA5);
        txq.push_back(8'hA5);
        txq.push_back(8'h00);
        applyStimulus();
        waitEnd("t6", 200, cyc);
        checkFrame("t6");
        checkOutput("t6_drop", 64'(dropCount), 64'(1));
        awDelay = 0;
        wrMode  = 0;

        // Reset in the middle of the payload.
        clearScore();
        portByte = 8'h01;
        randomPayload(20);
        buildFrame(8'h00);
        while (txq.size() > 11) void'(txq.pop_back());
        applyStimulus();
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        @(negedge CLK_I);
        checkIdleOutputs("t7_rst");
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
        repeat (5) @(negedge CLK_I);
        checkOutput("t7_noAck", 64'(ackCount), 64'(0));
        checkOutput("t7_noNak", 64'(nakCount), 64'(0));
        clearScore();
        randomPayload(9);
        buildFrame(8'h00);
        applyStimulus();
        waitEnd("t7b", 200, cyc);
        checkFrame("t7b");

        // Randomized frames with random backpressure.
        for (int f = 0; f < 6; f++) begin
            clearScore();
            wrMode   = 2;
            awDelay  = $urandom_range(0, 3);
            portByte = 8'($urandom_range(0, 255));
            randomPayload($urandom_range(1, 64));
            buildFrame(8'h00);
            applyStimulus();
            waitEnd($sformatf("r%0d", f), 2000, cyc);
            checkFrame($sformatf("r%0d", f));
        end
        wrMode  = 0;
        awDelay = 0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/serdes2axi4stream.md
Name: serdes2axi4stream

Overview:
- Receive-side counterpart of the AXI4-stream-to-SERDES framer. Accepts the byte stream recovered from the SERDES link and hunts for frame sync.
- Parses the header and buffers the payload in local RAM. A frame is released only after its CRC check passes.
- Replays the frame as an AW descriptor plus 64-bit W beats, and reports frame status to the link-level ack logic.
- Single clock domain: the SERDES parallel clock.

Parameters:
- MDATA_WIDTH, 64, output W data width (bits); must be 64.
- AWPORT_WIDTH, 2, width of M_AWPORT; taken from the low bits of the header PORT byte.
- AWLEN_WIDTH, 16, width of M_AWLEN (payload length in bytes).
- MAX_LEN, 256, maximum payload bytes; must be a multiple of 8. Sets buffer depth to MAX_LEN/8 words.
- BYTE_TIME_OUT, 1000, maximum idle cycles between bytes inside a frame before the frame is aborted.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  asynchronous, active-high reset
- RX_DATA_I  in  8  received byte
- RX_VALID_I  in  1  byte strobe; no backpressure toward the link
- RX_ACK_O  out  1  one-cycle pulse: frame fully delivered
- RX_NAK_O  out  1  one-cycle pulse: frame rejected
- RX_DROP_O  out  1  one-cycle pulse: sync seen while busy emitting, frame discarded
- BUSY_O  out  1  high from first sync byte until the last W beat is accepted
- M_AWPORT  out  AWPORT_WIDTH  destination port
- M_AWLEN  out  AWLEN_WIDTH  payload bytes
- M_AWVALID  out  1  descriptor valid
- M_AWREADY  in  1  descriptor ready
- M_WVALID  out  1  data valid
- M_WREADY  in  1  data ready
- M_WDATA  out  64  payload word
- M_WSTRB  out  8  byte enables
- M_WLAST  out  1  last beat

Behaviour:
- Reset: all outputs are 0 and the FSM is in HUNT.
- Frame format, on accepted bytes (RX_VALID_I=1):
  - 0xA5, 0xA5, PORT, LEN_H, LEN_L, LEN payload bytes, CRC8.
  - CRC8: polynomial 0x07, init 0x00, MSB-first, computed over PORT through the last payload byte.
- Packing: payload byte k goes to word k/8, bits [8*(k%8)+7 : 8*(k%8)] (little-endian).
- Beat count: words = ceil(LEN/8).
- Strobes: every beat uses 0xFF except the last, which uses (1<<(LEN%8))-1, or 0xFF when LEN%8==0.
- FSM states: HUNT, SYNC2, PORT, LENH, LENL, DATA, CRC, EMIT_AW, EMIT_W.
  - HUNT -> SYNC2 on 0xA5.
  - SYNC2: 0xA5 -> PORT; any other byte -> HUNT.
  - PORT -> LENH -> LENL, one byte each.
  - LENL: if the assembled LEN is 0 or >MAX_LEN -> NAK and HUNT; otherwise -> DATA.
  - DATA: writes one buffer word per 8 bytes, plus the final partial word on the last byte; after LEN bytes -> CRC.
  - CRC: on match -> EMIT_AW; on mismatch -> NAK and HUNT.
  - EMIT_AW: M_AWVALID held with stable PORT/LEN until M_AWREADY -> EMIT_W.
  - EMIT_W: beats are issued in order. WDATA/WSTRB/WLAST stay stable while WVALID=1 and WREADY=0. After the WLAST handshake, RX_ACK_O pulses the next cycle -> HUNT.
- Latency:
  - M_AWVALID rises 1 cycle after the CRC byte is accepted.
  - The first M_WVALID rises 1 cycle after the AW handshake.
  - With WREADY held high, the W phase sustains 1 beat per cycle (RAM read prefetched).
- Timeout: in SYNC2..CRC, an idle counter resets on every accepted byte. When it reaches BYTE_TIME_OUT -> NAK and HUNT. No timeout applies in HUNT, EMIT_AW or EMIT_W.
- RX_NAK_O pulses the cycle after the error-detecting byte, or after timeout expiry.
- Bytes during EMIT_AW/EMIT_W:
  - Bytes are ignored.
  - A 0xA5,0xA5 pair pulses RX_DROP_O once per pair.
  - The remainder of that frame is not parsed.
  - After emission, parsing restarts in HUNT.
- Simultaneous events: a NAK and a fresh 0xA5 on the same cycle in HUNT are both honoured (NAK pulse and transition to SYNC2).
- Reset mid-frame or mid-emit: the frame is discarded with no ACK/NAK; outputs return to reset values immediately.

Optional Feature:
- Macro: SERDES_RX_CRC_CHECK_EN.
- Defined: the CRC8 is computed and compared; a mismatch produces NAK.
- Undefined: the CRC byte is consumed and ignored, the CRC logic is not synthesized, and every well-formed frame is emitted.

Test Plan:
- PORT=2, LEN=11, payload 0x01..0x0B, correct CRC, AW/WREADY held high -> expected response:
  - AWPORT=2, AWLEN=11.
  - Beat0 0x0807060504030201 with strb 0xFF.
  - Beat1 0x00000000000B0A09 with strb 0x07 and WLAST.
  - One RX_ACK_O pulse.
- Same frame with the CRC byte XOR 0x01 -> one RX_NAK_O, no AWVALID. With the macro undefined, the frame emits normally.
- LEN=0 and LEN=MAX_LEN+1 -> NAK after LEN_L; with LEN=MAX_LEN (256) -> 32 beats, all strb 0xFF.
- Frame stalled after 3 payload bytes for BYTE_TIME_OUT cycles -> NAK; the next valid frame is received correctly.
- Frame LEN=16 with M_AWREADY delayed 5 cycles and WREADY toggling 1010 -> no beat lost or duplicated, data held stable during stalls. A second frame's 0xA5,0xA5 during emit -> one RX_DROP_O.
- RST_I asserted mid-DATA -> all outputs 0, no ACK/NAK; the next frame is received correctly.
